// File: rtl/uart_receiver.sv
// UART receiver: synchronizes rx, qualifies the start bit, samples each bit at mid-period
// and delivers the word through a valid/ack holding register with parity, frame and overrun flags.
module uart_receiver #(
    parameter int CLOCK_DIVISOR_WIDTH = 24
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           rx,
    input  logic [1:0]                     dataBits,
    input  logic                           hasParity,
    input  logic [1:0]                     parityMode,
    input  logic                           extraStopBit,
    input  logic [CLOCK_DIVISOR_WIDTH-1:0] clockDivisor,
    output logic                           busy,
    output logic [7:0]                     data,
    output logic                           dataValid,
    input  logic                           dataAck,
    output logic                           parityError,
    output logic                           frameError,
    output logic                           overrun
);

    localparam int W = CLOCK_DIVISOR_WIDTH;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

    state_t       state;
    state_t       state_next;
    logic         sync1;
    logic         rxs;
    logic         rxd;
    logic [W:0]   cnt;
    logic [W-1:0] div_l;
    logic [1:0]   bits_l;
    logic         par_l;
    logic [1:0]   pmode_l;
    logic         stop2_l;
    logic [7:0]   word;
    logic [2:0]   bit_idx;
    logic         par_err_p;
    logic         frm_err_p;
    logic         start_edge;
    logic         sample;
    logic         last_data;
    logic         par_expect;
    logic         frame_done;

    // Idle-high line, so the synchronizer chain resets to 1 to avoid a spurious start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
            rxd   <= 1'b1;
        end else begin
            sync1 <= rx;
            rxs   <= sync1;
            rxd   <= rxs;
        end
    end

    assign start_edge = rxd & ~rxs;
    assign sample     = (state == START) ? (cnt == {1'b0, div_l}) : (cnt == {div_l, 1'b1});
    assign last_data  = (bit_idx == ({1'b0, bits_l} + 3'd4));
    assign frame_done = sample & (((state == STOP1) & ~stop2_l) | (state == STOP2));

    always_comb begin
        par_expect = 1'b0;
        case (pmode_l)
            2'b00: par_expect = 1'b0;
            2'b11: par_expect = 1'b1;
            2'b10: par_expect = ^word;
            2'b01: par_expect = ~^word;
            default: par_expect = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (start_edge) state_next = START;
            START:  if (sample) state_next = rxs ? IDLE : DATA;
            DATA:   if (sample && last_data) state_next = par_l ? PARITY : STOP1;
            PARITY: if (sample) state_next = STOP1;
            STOP1:  if (sample) state_next = stop2_l ? STOP2 : IDLE;
            STOP2:  if (sample) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    // Frame datapath: configuration is frozen at the start edge so mid-frame changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            div_l     <= '0;
            bits_l    <= 2'd0;
            par_l     <= 1'b0;
            pmode_l   <= 2'd0;
            stop2_l   <= 1'b0;
            word      <= 8'h00;
            bit_idx   <= 3'd0;
            par_err_p <= 1'b0;
            frm_err_p <= 1'b0;
        end else if (state == IDLE) begin
            cnt <= '0;
            if (start_edge) begin
                div_l     <= clockDivisor;
                bits_l    <= dataBits;
                par_l     <= hasParity;
                pmode_l   <= parityMode;
                stop2_l   <= extraStopBit;
                word      <= 8'h00;
                bit_idx   <= 3'd0;
                par_err_p <= 1'b0;
                frm_err_p <= 1'b0;
            end
        end else if (sample) begin
            cnt <= '0;
            case (state)
                DATA: begin
                    word[bit_idx] <= rxs;
                    bit_idx       <= bit_idx + 3'd1;
                end
                PARITY: if (rxs != par_expect) par_err_p <= 1'b1;
                STOP1, STOP2: if (!rxs) frm_err_p <= 1'b1;
                default: ;
            endcase
        end else begin
            cnt <= cnt + (W+1)'(1);
        end
    end

    // Holding register; a completion coinciding with an ack is not an overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            data        <= 8'h00;
            dataValid   <= 1'b0;
            parityError <= 1'b0;
            frameError  <= 1'b0;
            overrun     <= 1'b0;
        end else if (frame_done) begin
            data        <= word;
            parityError <= par_err_p;
            frameError  <= frm_err_p | ~rxs;
            overrun     <= dataValid & ~dataAck;
            dataValid   <= 1'b1;
        end else if (dataAck && dataValid) begin
            dataValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: table of directed and randomized frames
// compared against a frame-level model, plus hand-written handshake/reset corner cases.
module tb_uart_receiver;

    logic        clk;
    logic        rst;
    logic        rx;
    logic [1:0]  data_bits;
    logic        has_parity;
    logic [1:0]  parity_mode;
    logic        extra_stop;
    logic [23:0] clock_divisor;
    logic        busy;
    logic [7:0]  data;
    logic        data_valid;
    logic        data_ack;
    logic        parity_error;
    logic        frame_error;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic [1:0] dbits;
        logic       has_par;
        logic [1:0] pmode;
        logic       extra;
        int         div;
        logic [7:0] word;
        logic       par_bit;
        logic       stop1;
        logic       stop2;
        logic [7:0] exp_data;
        logic       exp_par;
        logic       exp_frame;
    } vec_t;

    vec_t vecs[$];

    uart_receiver #(.CLOCK_DIVISOR_WIDTH(24)) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .dataBits(data_bits),
        .hasParity(has_parity),
        .parityMode(parity_mode),
        .extraStopBit(extra_stop),
        .clockDivisor(clock_divisor),
        .busy(busy),
        .data(data),
        .dataValid(data_valid),
        .dataAck(data_ack),
        .parityError(parity_error),
        .frameError(frame_error),
        .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Frame-level model: the parity value the wire should carry for a given word and mode.
    function automatic logic model_parity(input logic [7:0] w, input int nbits, input logic [1:0] mode);
        int ones = 0;
        for (int i = 0; i < nbits; i++) ones += int'(w[i]);
        case (mode)
            2'b00: return 1'b0;
            2'b11: return 1'b1;
            2'b10: return (ones % 2) == 1;
            default: return (ones % 2) == 0;
        endcase
    endfunction

    function automatic vec_t mk(input string name, input logic [1:0] dbits, input logic has_par,
                                input logic [1:0] pmode, input logic extra, input int div,
                                input logic [7:0] word, input logic par_bit, input logic stop1,
                                input logic stop2, input logic [7:0] exp_data, input logic exp_par,
                                input logic exp_frame);
        vec_t v;
        v.name = name; v.dbits = dbits; v.has_par = has_par; v.pmode = pmode; v.extra = extra;
        v.div = div; v.word = word; v.par_bit = par_bit; v.stop1 = stop1; v.stop2 = stop2;
        v.exp_data = exp_data; v.exp_par = exp_par; v.exp_frame = exp_frame;
        return v;
    endfunction

    function automatic vec_t mk_rand(input int idx);
        vec_t v;
        int nbits;
        logic good_par;
        v.name    = $sformatf("rand%0d", idx);
        v.dbits   = 2'($urandom_range(0, 3));
        v.has_par = 1'($urandom_range(0, 1));
        v.pmode   = 2'($urandom_range(0, 3));
        v.extra   = 1'($urandom_range(0, 1));
        v.div     = int'($urandom_range(0, 4));
        v.word    = 8'($urandom_range(0, 255));
        v.stop1   = ($urandom_range(0, 4) != 0);
        v.stop2   = ($urandom_range(0, 4) != 0);
        nbits     = int'(v.dbits) + 5;
        good_par  = model_parity(v.word, nbits, v.pmode);
        v.par_bit = good_par ^ ($urandom_range(0, 3) == 0);
        v.exp_data  = v.word & 8'((1 << nbits) - 1);
        v.exp_par   = v.has_par && (v.par_bit != good_par);
        v.exp_frame = !v.stop1 || (v.extra && !v.stop2);
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drives one frame with ideal bit timing; cut > 0 stops after that many bits.
    task automatic sendFrame(input vec_t v, input int cut, input bit scramble);
        logic bits[$];
        int p = 2 * (v.div + 1);
        @(negedge clk);
        data_bits     = v.dbits;
        has_parity    = v.has_par;
        parity_mode   = v.pmode;
        extra_stop    = v.extra;
        clock_divisor = 24'(v.div);
        rx            = 1'b1;
        repeat (4) @(negedge clk);
        bits.push_back(1'b0);
        for (int i = 0; i < int'(v.dbits) + 5; i++) bits.push_back(v.word[i]);
        if (v.has_par) bits.push_back(v.par_bit);
        bits.push_back(v.stop1);
        if (v.extra) bits.push_back(v.stop2);
        for (int i = 0; i < bits.size(); i++) begin
            if (cut > 0 && i == cut) break;
            if (scramble && i == 3) begin
                data_bits     = 2'($urandom_range(0, 3));
                has_parity    = 1'($urandom_range(0, 1));
                parity_mode   = 2'($urandom_range(0, 3));
                extra_stop    = 1'($urandom_range(0, 1));
                clock_divisor = 24'($urandom_range(0, 9));
            end
            rx = bits[i];
            repeat (p) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic applyStimulus(input vec_t v, input bit scramble);
        sendFrame(v, 0, scramble);
    endtask

    task automatic waitValid(input string name, input int budget);
        int n = 0;
        while (!data_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, " valid"}, 32'(data_valid), 32'd1);
    endtask

    task automatic ackWord(input string name, input logic [7:0] exp_data);
        @(negedge clk);
        data_ack = 1'b1;
        @(negedge clk);
        data_ack = 1'b0;
        checkOutput({name, " valid after ack"}, 32'(data_valid), 32'd0);
        checkOutput({name, " data kept"}, 32'(data), 32'(exp_data));
    endtask

    task automatic checkWord(input string name, input int div, input logic [7:0] exp_data,
                             input logic exp_par, input logic exp_frame, input logic exp_ovr);
        waitValid(name, 8 * (div + 1) + 20);
        checkOutput({name, " data"}, 32'(data), 32'(exp_data));
        checkOutput({name, " parityError"}, 32'(parity_error), 32'(exp_par));
        checkOutput({name, " frameError"}, 32'(frame_error), 32'(exp_frame));
        checkOutput({name, " overrun"}, 32'(overrun), 32'(exp_ovr));
        checkOutput({name, " busy"}, 32'(busy), 32'd0);
        ackWord(name, exp_data);
    endtask

    task automatic pulseReset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int n_plan;
        int busy_cycles;
        int valid_seen;
        vec_t v11, v22, v55, v3c, v5x;

        rst = 1'b1; rx = 1'b1; data_ack = 1'b0;
        data_bits = 2'd3; has_parity = 1'b0; parity_mode = 2'd0; extra_stop = 1'b0;
        clock_divisor = 24'd3;

        vecs.push_back(mk("8N1_A5",     2'd3, 1'b0, 2'b00, 1'b0, 3, 8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0));
        vecs.push_back(mk("7E1_35_ok",  2'd2, 1'b1, 2'b10, 1'b0, 3, 8'h35, 1'b0, 1'b1, 1'b1, 8'h35, 1'b0, 1'b0));
        vecs.push_back(mk("7E1_35_bad", 2'd2, 1'b1, 2'b10, 1'b0, 3, 8'h35, 1'b1, 1'b1, 1'b1, 8'h35, 1'b1, 1'b0));
        vecs.push_back(mk("5O2_stop2",  2'd0, 1'b1, 2'b01, 1'b1, 3, 8'h1F, 1'b0, 1'b1, 1'b0, 8'h1F, 1'b0, 1'b1));
        vecs.push_back(mk("5N1_div0",   2'd0, 1'b0, 2'b00, 1'b0, 0, 8'hFF, 1'b0, 1'b1, 1'b1, 8'h1F, 1'b0, 1'b0));
        vecs.push_back(mk("6M1_ok",     2'd1, 1'b1, 2'b11, 1'b0, 1, 8'hEA, 1'b1, 1'b1, 1'b1, 8'h2A, 1'b0, 1'b0));
        vecs.push_back(mk("8S1_bad",    2'd3, 1'b1, 2'b00, 1'b0, 1, 8'h3C, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0));
        vecs.push_back(mk("8N1_stop1",  2'd3, 1'b0, 2'b00, 1'b0, 2, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1));
        n_plan = vecs.size();
        for (int i = 0; i < 16; i++) vecs.push_back(mk_rand(i));

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset dataValid", 32'(data_valid), 32'd0);
        checkOutput("reset data", 32'(data), 32'd0);
        checkOutput("reset parityError", 32'(parity_error), 32'd0);
        checkOutput("reset frameError", 32'(frame_error), 32'd0);
        checkOutput("reset overrun", 32'(overrun), 32'd0);

        // Ack with nothing held must be ignored.
        data_ack = 1'b1;
        repeat (2) @(negedge clk);
        data_ack = 1'b0;
        checkOutput("idle ack", 32'(data_valid), 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], i >= n_plan);
            checkWord(vecs[i].name, vecs[i].div, vecs[i].exp_data, vecs[i].exp_par, vecs[i].exp_frame, 1'b0);
        end

        // Same 5O2 line but only one stop bit configured: the low second stop bit is ignored.
        v5x = mk("5O1_line", 2'd0, 1'b1, 2'b01, 1'b0, 3, 8'h1F, 1'b0, 1'b1, 1'b0, 8'h1F, 1'b0, 1'b0);
        sendFrame(v5x, 0, 1'b0);
        rx = 1'b0;
        repeat (8) @(negedge clk);
        rx = 1'b1;
        waitValid("5O1_line", 40);
        checkOutput("5O1_line data", 32'(data), 32'h1F);
        checkOutput("5O1_line frameError", 32'(frame_error), 32'd0);
        checkOutput("5O1_line parityError", 32'(parity_error), 32'd0);
        pulseReset();
        checkOutput("post-reset dataValid", 32'(data_valid), 32'd0);
        checkOutput("post-reset data", 32'(data), 32'd0);
        checkOutput("post-reset busy", 32'(busy), 32'd0);

        // False start: a 2-cycle glitch keeps busy high for exactly Dl+1 cycles.
        @(negedge clk);
        clock_divisor = 24'd7;
        repeat (4) @(negedge clk);
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        busy_cycles = 0;
        valid_seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy) busy_cycles++;
            if (data_valid) valid_seen++;
        end
        checkOutput("false start busy cycles", 32'(busy_cycles), 32'd8);
        checkOutput("false start no word", 32'(valid_seen), 32'd0);
        checkOutput("false start idle", 32'(busy), 32'd0);

        // Back-to-back without ack: second word flags overrun.
        v11 = mk("b2b_11", 2'd3, 1'b0, 2'b00, 1'b0, 3, 8'h11, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0);
        v22 = mk("b2b_22", 2'd3, 1'b0, 2'b00, 1'b0, 3, 8'h22, 1'b0, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0);
        sendFrame(v11, 0, 1'b0);
        waitValid("b2b first", 40);
        sendFrame(v22, 0, 1'b0);
        checkWord("b2b overrun", 3, 8'h22, 1'b0, 1'b0, 1'b1);

        // Ack lands exactly in the completion cycle (cycle Dl+1+9P after the start edge).
        sendFrame(v11, 0, 1'b0);
        waitValid("sim first", 40);
        fork
            sendFrame(v22, 0, 1'b0);
            begin
                @(negedge rx);
                repeat (3 + 2 + 9 * 8 + 1) @(negedge clk);
                data_ack = 1'b1;
                checkOutput("sim pre-edge valid", 32'(data_valid), 32'd1);
                checkOutput("sim pre-edge data", 32'(data), 32'h11);
                @(negedge clk);
                data_ack = 1'b0;
                checkOutput("sim valid", 32'(data_valid), 32'd1);
                checkOutput("sim data", 32'(data), 32'h22);
                checkOutput("sim overrun", 32'(overrun), 32'd0);
            end
        join
        checkWord("sim word", 3, 8'h22, 1'b0, 1'b0, 1'b0);

        // Reset mid-frame discards the partial word; the next frame is clean.
        v55 = mk("rst_55", 2'd3, 1'b0, 2'b00, 1'b0, 3, 8'h55, 1'b0, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
        v3c = mk("rst_3C", 2'd3, 1'b0, 2'b00, 1'b0, 3, 8'h3C, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0);
        sendFrame(v55, 4, 1'b0);
        checkOutput("mid-frame busy", 32'(busy), 32'd1);
        pulseReset();
        checkOutput("abort busy", 32'(busy), 32'd0);
        valid_seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (data_valid) valid_seen++;
        end
        checkOutput("abort no word", 32'(valid_seen), 32'd0);
        sendFrame(v3c, 0, 1'b0);
        checkWord("after abort", 3, 8'h3C, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
